// File: rtl/srv_defs.sv
// Shared definitions for the pipeline sequencer (pipe_ctrl).
// Provides the default pipeline geometry, the stage-index type used for
// flush ranges and the per-stage lane-valid vector type.
package srv_defs;

    localparam int unsigned PIPE_STAGES = 4;
    localparam int unsigned PIPE_LANES  = 2;
    localparam int unsigned PIPE_CNT_W  = 32;

    typedef logic [$clog2(PIPE_STAGES)-1:0] pipe_stage_idx_t;
    typedef logic [PIPE_LANES-1:0]          lane_valid_t;

endpackage

// File: rtl/pipe_ctrl_stage.sv
// One tracked pipeline stage: lane-valid register, advance/ready terms and
// (when PIPE_CTRL_PERF_EN is defined) saturating stall/bubble counters.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   i_src_valid     lane valids of the source feeding this stage
//   i_load          load i_src_valid this cycle
//   i_kill          stage is flushed this cycle (highest priority)
//   i_busy          stage holds its packet this cycle
//   i_rdy_next      next-older stage (or sink) can take a packet
//   perf_clr        synchronous counter clear (perf build only)
//   o_lane_valid    registered lane valids
//   o_adv           packet leaves this stage this cycle
//   o_rdy           stage can accept a packet this cycle
//   o_stall_cnt     cycles valid but not advancing
//   o_bubble_cnt    cycles empty
module pipe_ctrl_stage
    import srv_defs::*;
#(
    parameter int unsigned LANES = PIPE_LANES,
    parameter int unsigned CNT_W = PIPE_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [LANES-1:0] i_src_valid,
    input  logic             i_load,
    input  logic             i_kill,
    input  logic             i_busy,
    input  logic             i_rdy_next,
    input  logic             perf_clr,
    output logic [LANES-1:0] o_lane_valid,
    output logic             o_adv,
    output logic             o_rdy,
    output logic [CNT_W-1:0] o_stall_cnt,
    output logic [CNT_W-1:0] o_bubble_cnt
);

    logic [LANES-1:0] r_valid;
    logic             w_v;

    assign w_v          = |r_valid;
    // Busy on an empty stage has no effect because adv requires w_v.
    assign o_adv        = w_v && !i_busy && i_rdy_next;
    assign o_rdy        = !w_v || o_adv;
    assign o_lane_valid = r_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= '0;
        end else if (i_kill) begin
            r_valid <= '0;
        end else if (i_load) begin
            r_valid <= i_src_valid;
        end else if (o_adv) begin
            r_valid <= '0;
        end
    end

`ifdef PIPE_CTRL_PERF_EN
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_bubble_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt  <= '0;
            r_bubble_cnt <= '0;
        end else if (perf_clr) begin
            r_stall_cnt  <= '0;
            r_bubble_cnt <= '0;
        end else begin
            if (w_v && !o_adv && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
            if (!w_v && (r_bubble_cnt != '1)) begin
                r_bubble_cnt <= r_bubble_cnt + CNT_W'(1);
            end
        end
    end

    assign o_stall_cnt  = r_stall_cnt;
    assign o_bubble_cnt = r_bubble_cnt;
`else
    logic w_unused_perf_clr;
    assign w_unused_perf_clr = perf_clr;
    assign o_stall_cnt       = '0;
    assign o_bubble_cnt      = '0;
`endif

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer for the dual-issue core. Tracks per-stage, per-lane
// valid bits, produces chained advance enables so bubbles collapse, and
// applies ranged flushes (stages 0..flush_stage).
// Optional macro PIPE_CTRL_PERF_EN adds per-stage stall/bubble counters;
// without it the perf outputs read 0 and perf_clr is ignored.
// Ports:
//   clk, rst         clock, asynchronous active-high reset
//   in_valid/ready   front-end packet offer / acceptance by stage 0
//   stage_busy       per-stage hold request
//   out_ready        sink accepts the oldest packet
//   out_valid/fire   oldest stage lane valids / packet leaves
//   stage_valid      all registered lane valids, stage-major
//   stage_load       data-register load enable per stage
//   stage_kill       per-stage flush indication
//   flush_req/stage  ranged flush request and oldest killed stage
//   perf_clr         counter clear
//   perf_*_cnt       per-stage stall / bubble counters
module pipe_ctrl
    import srv_defs::*;
#(
    parameter int unsigned STAGES = PIPE_STAGES,
    parameter int unsigned LANES  = PIPE_LANES,
    parameter int unsigned CNT_W  = PIPE_CNT_W
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [LANES-1:0]          in_valid,
    output logic                      in_ready,
    input  logic [STAGES-1:0]         stage_busy,
    input  logic                      out_ready,
    output logic [LANES-1:0]          out_valid,
    output logic                      out_fire,
    output logic [STAGES*LANES-1:0]   stage_valid,
    output logic [STAGES-1:0]         stage_load,
    output logic [STAGES-1:0]         stage_kill,
    input  logic                      flush_req,
    input  logic [$clog2(STAGES)-1:0] flush_stage,
    input  logic                      perf_clr,
    output logic [STAGES*CNT_W-1:0]   perf_stall_cnt,
    output logic [STAGES*CNT_W-1:0]   perf_bubble_cnt
);

    // rdy/adv live in per-stage scopes so the ready chain is not a single
    // self-referencing vector.
    for (genvar i = 0; i < STAGES; i++) begin : g_stage
        logic             w_rdy;
        logic             w_adv;
        logic             w_rdy_next;
        logic [LANES-1:0] w_src;

        if (i == 0) begin : g_head
            assign w_src         = in_valid;
            assign stage_load[i] = (|in_valid) && in_ready;
        end else begin : g_body
            assign w_src         = stage_valid[(i-1)*LANES +: LANES];
            // A packet leaving a killed stage must not land in the next one.
            assign stage_load[i] = g_stage[i-1].w_adv &&
                                   !(flush_req && (int'(flush_stage) >= i - 1));
        end

        if (i == STAGES - 1) begin : g_tail
            assign w_rdy_next = out_ready;
        end else begin : g_mid
            assign w_rdy_next = g_stage[i+1].w_rdy;
        end

        assign stage_kill[i] = flush_req && (int'(flush_stage) >= i);

        pipe_ctrl_stage #(
            .LANES (LANES),
            .CNT_W (CNT_W)
        ) u_stage (
            .clk          (clk),
            .rst          (rst),
            .i_src_valid  (w_src),
            .i_load       (stage_load[i]),
            .i_kill       (stage_kill[i]),
            .i_busy       (stage_busy[i]),
            .i_rdy_next   (w_rdy_next),
            .perf_clr     (perf_clr),
            .o_lane_valid (stage_valid[i*LANES +: LANES]),
            .o_adv        (w_adv),
            .o_rdy        (w_rdy),
            .o_stall_cnt  (perf_stall_cnt[i*CNT_W +: CNT_W]),
            .o_bubble_cnt (perf_bubble_cnt[i*CNT_W +: CNT_W])
        );
    end

    assign in_ready  = g_stage[0].w_rdy && !flush_req;
    assign out_valid = stage_valid[(STAGES-1)*LANES +: LANES];
    assign out_fire  = g_stage[STAGES-1].w_adv;

endmodule

// File: tb/tb_pipe_ctrl.sv
module tb_pipe_ctrl;

    localparam int unsigned S  = 4;
    localparam int unsigned L  = 2;
    localparam int unsigned CW = 32;
`ifdef PIPE_CTRL_PERF_EN
    localparam bit PERF_ON = 1'b1;
`else
    localparam bit PERF_ON = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic [L-1:0]     in_valid;
    logic             in_ready;
    logic [S-1:0]     stage_busy;
    logic             out_ready;
    logic [L-1:0]     out_valid;
    logic             out_fire;
    logic [S*L-1:0]   stage_valid;
    logic [S-1:0]     stage_load;
    logic [S-1:0]     stage_kill;
    logic             flush_req;
    logic [1:0]       flush_stage;
    logic             perf_clr;
    logic [S*CW-1:0]  perf_stall_cnt;
    logic [S*CW-1:0]  perf_bubble_cnt;

    pipe_ctrl #(
        .STAGES (S),
        .LANES  (L),
        .CNT_W  (CW)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .stage_busy      (stage_busy),
        .out_ready       (out_ready),
        .out_valid       (out_valid),
        .out_fire        (out_fire),
        .stage_valid     (stage_valid),
        .stage_load      (stage_load),
        .stage_kill      (stage_kill),
        .flush_req       (flush_req),
        .flush_stage     (flush_stage),
        .perf_clr        (perf_clr),
        .perf_stall_cnt  (perf_stall_cnt),
        .perf_bubble_cnt (perf_bubble_cnt)
    );

    always #5 clk = ~clk;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    // Reference model: contents of each pipeline slot, and counters.
    logic [L-1:0]  m_lanes [S];
    logic [CW-1:0] m_stall [S];
    logic [CW-1:0] m_bub   [S];
    logic [L-1:0]  n_lanes [S];
    logic [CW-1:0] n_stall [S];
    logic [CW-1:0] n_bub   [S];

    logic          e_in_ready, e_out_fire;
    logic [S-1:0]  e_load, e_kill;

    // Values seen in the most recent cycle, for directed literal checks.
    logic          obs_in_ready, obs_out_fire;
    logic [L-1:0]  obs_out_valid;
    logic [S*L-1:0] obs_sv;
    logic [S-1:0]  obs_load, obs_kill;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int s = 0; s < S; s++) begin
            m_lanes[s] = '0;
            m_stall[s] = '0;
            m_bub[s]   = '0;
        end
    endtask

    // Slot-level view: a packet moves when its slot is occupied, not held,
    // and the slot ahead (or the sink) is vacated this cycle.
    task automatic model_eval();
        bit moves [S];
        bit full  [S];
        bit ahead_free;
        bit killed;
        ahead_free = out_ready;
        for (int s = S - 1; s >= 0; s--) begin
            full[s]  = (m_lanes[s] != '0);
            moves[s] = full[s] && !stage_busy[s] && ahead_free;
            ahead_free = !full[s] || moves[s];
        end
        e_in_ready = ahead_free && !flush_req;
        e_out_fire = moves[S-1];
        for (int s = 0; s < S; s++) begin
            e_kill[s] = flush_req && (s <= int'(flush_stage));
            if (s == 0) e_load[s] = (in_valid != '0) && e_in_ready;
            else        e_load[s] = moves[s-1] && !(flush_req && (s - 1 <= int'(flush_stage)));
        end
        for (int s = 0; s < S; s++) begin
            killed = e_kill[s];
            if (killed)          n_lanes[s] = '0;
            else if (e_load[s])  n_lanes[s] = (s == 0) ? in_valid : m_lanes[s-1];
            else if (moves[s])   n_lanes[s] = '0;
            else                 n_lanes[s] = m_lanes[s];
            n_stall[s] = m_stall[s];
            n_bub[s]   = m_bub[s];
            if (PERF_ON) begin
                if (perf_clr) begin
                    n_stall[s] = '0;
                    n_bub[s]   = '0;
                end else begin
                    if (full[s] && !moves[s] && m_stall[s] != '1) n_stall[s] = m_stall[s] + 1;
                    if (!full[s] && m_bub[s] != '1)                n_bub[s]   = m_bub[s] + 1;
                end
            end
        end
    endtask

    task automatic cyc(input logic [L-1:0] iv, input logic [S-1:0] bz, input logic ordy,
                       input logic fr, input logic [1:0] fs, input logic pc);
        logic [S*L-1:0]  e_sv;
        logic [S*CW-1:0] e_st, e_bb;
        in_valid    = iv;
        stage_busy  = bz;
        out_ready   = ordy;
        flush_req   = fr;
        flush_stage = fs;
        perf_clr    = pc;
        #1;
        model_eval();
        for (int s = 0; s < S; s++) begin
            e_sv[s*L +: L]   = m_lanes[s];
            e_st[s*CW +: CW] = m_stall[s];
            e_bb[s*CW +: CW] = m_bub[s];
        end
        chk("in_ready",    in_ready,        e_in_ready);
        chk("out_fire",    out_fire,        e_out_fire);
        chk("out_valid",   out_valid,       m_lanes[S-1]);
        chk("stage_valid", stage_valid,     e_sv);
        chk("stage_load",  stage_load,      e_load);
        chk("stage_kill",  stage_kill,      e_kill);
        chk("perf_stall",  perf_stall_cnt,  e_st);
        chk("perf_bubble", perf_bubble_cnt, e_bb);
        obs_in_ready  = in_ready;
        obs_out_fire  = out_fire;
        obs_out_valid = out_valid;
        obs_sv        = stage_valid;
        obs_load      = stage_load;
        obs_kill      = stage_kill;
        @(posedge clk);
        for (int s = 0; s < S; s++) begin
            m_lanes[s] = n_lanes[s];
            m_stall[s] = n_stall[s];
            m_bub[s]   = n_bub[s];
        end
        @(negedge clk);
    endtask

    task automatic idle(input logic ordy, input int unsigned n);
        for (int unsigned k = 0; k < n; k++) cyc('0, '0, ordy, 1'b0, 2'd0, 1'b0);
    endtask

    initial begin
        int unsigned acc;
        int unsigned fires;
        logic [CW-1:0] b0, b1;
        logic [L-1:0]  riv;
        logic [S-1:0]  rbz;

        rst = 1'b1;
        in_valid = '0; stage_busy = '0; out_ready = 1'b0;
        flush_req = 1'b0; flush_stage = '0; perf_clr = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        chk("rst_in_ready",    in_ready,        1);
        chk("rst_stage_valid", stage_valid,     0);
        chk("rst_out_valid",   out_valid,       0);
        chk("rst_out_fire",    out_fire,        0);
        chk("rst_stage_load",  stage_load,      0);
        chk("rst_stage_kill",  stage_kill,      0);
        chk("rst_perf",        {perf_stall_cnt, perf_bubble_cnt}, 0);
        rst = 1'b0;

        // Fill/drain: out_valid 4 cycles after the offer.
        cyc(2'b11, '0, 1'b1, 1'b0, 2'd0, 1'b0);
        idle(1'b1, 3);
        cyc('0, '0, 1'b1, 1'b0, 2'd0, 1'b0);
        chk("fill_out_valid", obs_out_valid, 2'b11);
        chk("fill_out_fire",  obs_out_fire,  1);
        cyc('0, '0, 1'b1, 1'b0, 2'd0, 1'b0);
        chk("drain_empty", obs_sv, 0);

        // Backpressure collapse.
        acc = 0;
        for (int k = 0; k < 6; k++) begin
            cyc(2'b11, '0, 1'b0, 1'b0, 2'd0, 1'b0);
            if (obs_in_ready) acc++;
        end
        chk("bp_accepted", acc, 4);
        fires = 0;
        cyc(2'b11, '0, 1'b1, 1'b0, 2'd0, 1'b0);
        chk("bp_first_fire", obs_out_fire, 1);
        chk("bp_5th_accept", obs_in_ready, 1);
        if (obs_out_fire) fires++;
        cyc(2'b10, '0, 1'b1, 1'b0, 2'd0, 1'b0);
        if (obs_out_fire) fires++;
        for (int k = 0; k < 2; k++) begin
            cyc('0, '0, 1'b1, 1'b0, 2'd0, 1'b0);
            if (obs_out_fire) fires++;
        end
        chk("bp_fire_run", fires, 4);
        idle(1'b1, 4);

        // Busy bubble: one packet parked in stage 2, held busy for 3 cycles.
        cyc(2'b11, '0, 1'b0, 1'b0, 2'd0, 1'b0);
        idle(1'b0, 2);
        b0 = perf_bubble_cnt[3*CW +: CW];
        for (int k = 0; k < 3; k++) begin
            cyc(2'b10, 4'b0100, 1'b1, 1'b0, 2'd0, 1'b0);
            chk("busy_no_load3", obs_load[3], 0);
        end
        b1 = perf_bubble_cnt[3*CW +: CW];
        chk("busy_bubble3", b1 - b0, PERF_ON ? 3 : 0);
        chk("busy_young_in", obs_sv[3:0], 4'b1010);
        idle(1'b1, 6);

        // Lane pattern.
        cyc(2'b01, '0, 1'b1, 1'b0, 2'd0, 1'b0);
        idle(1'b1, 3);
        cyc('0, '0, 1'b1, 1'b0, 2'd0, 1'b0);
        chk("lane01_out", obs_out_valid, 2'b01);

        // Ranged flush with a full pipeline.
        cyc(2'b11, '0, 1'b0, 1'b0, 2'd0, 1'b0);
        cyc(2'b10, '0, 1'b0, 1'b0, 2'd0, 1'b0);
        cyc(2'b01, '0, 1'b0, 1'b0, 2'd0, 1'b0);
        cyc(2'b11, '0, 1'b0, 1'b0, 2'd0, 1'b0);
        cyc(2'b11, '0, 1'b1, 1'b1, 2'd1, 1'b0);
        chk("flush_in_ready", obs_in_ready, 0);
        chk("flush_kill",     obs_kill,     4'b0011);
        chk("flush_load2",    obs_load[2],  0);
        chk("flush_fire",     obs_out_fire, 1);
        cyc('0, '0, 1'b0, 1'b0, 2'd0, 1'b0);
        chk("flush_after", obs_sv, 8'h80);
        idle(1'b1, 2);

        // Async reset mid-stream.
        for (int k = 0; k < 4; k++) cyc(2'b11, '0, 1'b0, 1'b0, 2'd0, 1'b0);
        #2 rst = 1'b1;
        #1;
        chk("arst_stage_valid", stage_valid, 0);
        chk("arst_in_ready",    in_ready,    1);
        chk("arst_perf",        {perf_stall_cnt, perf_bubble_cnt}, 0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;

        // Randomized traffic.
        for (int k = 0; k < 600; k++) begin
            riv = L'($urandom_range(0, 3));
            for (int s = 0; s < S; s++) rbz[s] = ($urandom_range(0, 4) == 0);
            cyc(riv, rbz, ($urandom_range(0, 3) != 0), ($urandom_range(0, 9) == 0),
                2'($urandom_range(0, 3)), ($urandom_range(0, 19) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
